// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the P-Core datapath:
// sizes, FSM encoding, round constants and the word rotate helper.
package aes_pkg;

  localparam int NR = 10;
  localparam int NW = 4 * (NR + 1);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } ks_state_t;

  // Rcon for round index 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Shared between the key expander and the P-Core round logic.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/key_expander.sv
// AES-128 key schedule: produces one schedule word per cycle into a 44x32
// register file and serves 128-bit round keys by index once complete.
module key_expander
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR,
  parameter int NW = aes_pkg::NW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         KeyLogicStart,
  input  logic         KeyLogicMode,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         KeyLogic_Done
);

  ks_state_t   state;
  logic [5:0]  i;
  logic [31:0] words [NW];

  logic [31:0] prev, back4, rot, sub, temp, w_new;
  logic [3:0]  sel_c;
  logic        rd_ok;

  assign prev  = words[i - 6'd1];
  assign back4 = words[i - 6'd4];
  assign rot   = rot_word(prev);

  // SubWord: one S-box per byte lane of the rotated word.
  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .din  (rot[8*b +: 8]),
      .dout (sub[8*b +: 8])
    );
  end

  assign temp  = (i[1:0] == 2'd0) ? (sub ^ {rcon(i[5:2]), 24'h0}) : prev;
  assign w_new = back4 ^ temp;

  assign rd_ok = KeyLogic_Done && KeyLogicMode && (round_sel <= 4'(NR));
  // Clamp so the slice never leaves the array; gated to zero anyway.
  assign sel_c = (round_sel <= 4'(NR)) ? round_sel : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      i             <= 6'd4;
      KeyLogic_Done <= 1'b0;
      round_key     <= '0;
    end else begin
      if (KeyLogicStart) begin
        state         <= GEN;
        i             <= 6'd4;
        KeyLogic_Done <= 1'b0;
      end else if (state == GEN) begin
        if (i == 6'(NW - 1)) begin
          state         <= IDLE;
          i             <= 6'd4;
          KeyLogic_Done <= 1'b1;
        end else begin
          i <= i + 6'd1;
        end
      end
      round_key <= rd_ok ? {words[{sel_c, 2'd0}], words[{sel_c, 2'd1}],
                            words[{sel_c, 2'd2}], words[{sel_c, 2'd3}]} : '0;
    end
  end

  // Storage carries no reset: contents are meaningless until Done rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (KeyLogicStart) begin
        words[0] <= key_in[127:96];
        words[1] <= key_in[95:64];
        words[2] <= key_in[63:32];
        words[3] <= key_in[31:0];
      end else if (state == GEN) begin
        words[i] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: FIPS-197 vectors plus random keys checked against
// a GF(2^8)-derived reference schedule held in the bench.
module tb_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         KeyLogicStart;
  logic         KeyLogicMode;
  logic [127:0] key_in;
  logic [3:0]   round_sel;
  logic [127:0] round_key;
  logic         KeyLogic_Done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_ref [256];
  logic [31:0] ref_w [44];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  key_expander dut (
    .clk           (clk),
    .rst           (rst),
    .KeyLogicStart (KeyLogicStart),
    .KeyLogicMode  (KeyLogicMode),
    .key_in        (key_in),
    .round_sel     (round_sel),
    .round_key     (round_key),
    .KeyLogic_Done (KeyLogic_Done)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // GF(2^8) arithmetic used to derive the S-box from first principles.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      if (v == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int k = 0; k < 4; k++) ref_w[k] = key[127 - 32*k -: 32];
    for (int k = 4; k < 44; k++) begin
      t = ref_w[k-1];
      if (k % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = xt(rc);
      end
      ref_w[k] = ref_w[k-4] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] key);
    key_in        = key;
    KeyLogicStart = 1'b1;
    step();
    KeyLogicStart = 1'b0;
    key_in        = '0;
  endtask

  // Counts edges after the start edge until Done; 100 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (!KeyLogic_Done && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic rd(input int sel, input logic mode, output logic [127:0] rk);
    round_sel    = 4'(sel);
    KeyLogicMode = mode;
    step();
    rk = round_key;
  endtask

  initial begin
    logic [127:0] rk, key;
    int n, sel;

    rst = 1'b1; KeyLogicStart = 1'b0; KeyLogicMode = 1'b0;
    key_in = '0; round_sel = '0;
    build_sbox();
    step(); step();
    chk("reset_done", 128'(KeyLogic_Done), 128'd0);
    chk("reset_rk", round_key, 128'd0);
    rst = 1'b0;
    step();

    // FIPS-197 vector
    start(FIPS_KEY);
    chk("fips_done_low_t0", 128'(KeyLogic_Done), 128'd0);
    wait_done(n);
    chk("fips_latency", 128'(n), 128'd40);
    rd(1, 1'b1, rk);  chk("fips_r1", rk, FIPS_R1);
    rd(10, 1'b1, rk); chk("fips_r10", rk, FIPS_R10);
    rd(0, 1'b1, rk);  chk("fips_r0", rk, FIPS_KEY);
    rd(10, 1'b0, rk); chk("mode0_gate", rk, 128'd0);
    rd(12, 1'b1, rk); chk("sel12_gate", rk, 128'd0);

    // All-zero key
    start('0);
    wait_done(n);
    chk("zero_latency", 128'(n), 128'd40);
    rd(1, 1'b1, rk);  chk("zero_r1", rk, ZERO_R1);
    rd(10, 1'b1, rk); chk("zero_r10", rk, ZERO_R10);

    // Restart mid-GEN: zero key aborted by the FIPS key after 15 cycles
    start('0);
    for (int k = 0; k < 14; k++) step();
    chk("restart_done_low", 128'(KeyLogic_Done), 128'd0);
    start(FIPS_KEY);
    wait_done(n);
    chk("restart_latency", 128'(n), 128'd40);
    rd(10, 1'b1, rk); chk("restart_r10", rk, FIPS_R10);

    // Reset in the middle of generation
    KeyLogicMode = 1'b1;
    round_sel    = 4'd1;
    start(FIPS_KEY);
    for (int k = 0; k < 19; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstgen_done", 128'(KeyLogic_Done), 128'd0);
    chk("rstgen_rk", round_key, 128'd0);
    for (int k = 0; k < 30; k++) step();
    chk("rstgen_done_later", 128'(KeyLogic_Done), 128'd0);
    rd(1, 1'b1, rk); chk("rstgen_read", rk, 128'd0);

    // Start and reset in the same cycle: reset dominates, nothing begins
    rst = 1'b1;
    start(FIPS_KEY);
    rst = 1'b0;
    for (int k = 0; k < 45; k++) step();
    chk("rst_beats_start", 128'(KeyLogic_Done), 128'd0);

    // Controller-style flow: start, then Mode=0 while waiting
    KeyLogicMode = 1'b0;
    start(FIPS_KEY);
    chk("flow_first_wait", 128'(KeyLogic_Done), 128'd0);
    wait_done(n);
    chk("flow_latency", 128'(n), 128'd40);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (KeyLogic_Done !== 1'b1 || round_key !== '0) n++;
    end
    chk("flow_stable_idle", 128'(n), 128'd0);

    // Random keys against the reference schedule
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      expand_ref(key);
      start(key);
      wait_done(n);
      chk($sformatf("rand%0d_latency", t), 128'(n), 128'd40);
      for (int r = 0; r <= 10; r++) begin
        rd(r, 1'b1, rk);
        chk($sformatf("rand%0d_r%0d", t, r), rk, ref_rk(r));
      end
      sel = 11 + int'($urandom_range(0, 4));
      rd(sel, 1'b1, rk);
      chk($sformatf("rand%0d_sel%0d", t, sel), rk, 128'd0);
      rd(int'($urandom_range(0, 10)), 1'b0, rk);
      chk($sformatf("rand%0d_mode0", t), rk, 128'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
